// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Boot-time loader for the S-Machine. A byte-serial program image arrives over
// a valid/ready link, is assembled into 16-bit instruction words and written
// into instruction memory through a dedicated write port. An XOR checksum over
// the data bytes is verified at the end; the CPU enable is raised only after a
// successful load and is held low while loading and after any load error.
//
// Stream format: LEN_HI, LEN_LO, LEN x (word_hi, word_lo), checksum byte.
// The checksum is the XOR of the data bytes only (length bytes excluded).
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   load_start   one-cycle pulse, starts a load from IDLE, DONE or ERROR
//   rx_data      incoming byte
//   rx_valid     rx_data valid
//   rx_ready     loader accepts a byte this cycle (combinational from state)
//   wr_en        instruction memory write strobe (one cycle per word)
//   wr_addr      instruction memory write address
//   wr_data      instruction word {hi, lo}
//   cpu_enable   S-Machine enable
//   busy         load in progress
//   done         last load succeeded
//   error        last load failed
//   words_loaded words written in the current/last load
//
// DATA_WIDTH must be 16 (two bytes per word).
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  cpu_enable,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LEN_HI  = 3'd1;
  localparam logic [2:0] S_LEN_LO  = 3'd2;
  localparam logic [2:0] S_DATA_HI = 3'd3;
  localparam logic [2:0] S_DATA_LO = 3'd4;
  localparam logic [2:0] S_CHECK   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;
  localparam logic [2:0] S_ERROR   = 3'd7;

  // Largest legal length is a full memory, 2^ADDR_WIDTH words.
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_WIDTH;

  // The idle counter only has to reach TIMEOUT_CYCLES-1: the timeout fires on
  // the edge that would have taken it to TIMEOUT_CYCLES.
  localparam int              TW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [2:0]            state_reg;
  logic [7:0]            len_hi_reg;
  logic [ADDR_WIDTH-1:0] last_index_reg;
  logic [ADDR_WIDTH-1:0] index_reg;
  logic [7:0]            hi_byte_reg;
  logic [7:0]            csum_reg;
  logic [TW-1:0]         timer_reg;

  logic        accept;
  logic        timeout_hit;
  logic [15:0] len_full;

  assign busy     = (state_reg >= S_LEN_HI) && (state_reg <= S_CHECK);
  assign rx_ready = busy;
  assign accept   = rx_valid && rx_ready;
  assign len_full = {len_hi_reg, rx_data};

  // A byte accepted on the expiring cycle wins over the timeout.
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end else begin : g_timeout
      assign timeout_hit = busy && !accept && (timer_reg == TIMER_LAST);
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= S_IDLE;
      len_hi_reg     <= '0;
      last_index_reg <= '0;
      index_reg      <= '0;
      hi_byte_reg    <= '0;
      csum_reg       <= '0;
      timer_reg      <= '0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      cpu_enable     <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      words_loaded   <= '0;
    end else begin
      wr_en <= 1'b0;

      if (busy) begin
        if (accept) begin
          timer_reg <= '0;
        end else if (timer_reg != TIMER_LAST) begin
          timer_reg <= timer_reg + 1'b1;
        end
      end

      case (state_reg)
        S_IDLE, S_DONE, S_ERROR: begin
          if (load_start) begin
            state_reg    <= S_LEN_HI;
            timer_reg    <= '0;
            done         <= 1'b0;
            error        <= 1'b0;
            cpu_enable   <= 1'b0;
            words_loaded <= '0;
          end
        end
        S_LEN_HI: begin
          if (accept) begin
            len_hi_reg <= rx_data;
            state_reg  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            if (len_full == 16'd0 || {1'b0, len_full} > MAX_LEN) begin
              state_reg <= S_ERROR;
              error     <= 1'b1;
            end else begin
              last_index_reg <= ADDR_WIDTH'(len_full - 16'd1);
              index_reg      <= '0;
              csum_reg       <= '0;
              state_reg      <= S_DATA_HI;
            end
          end
        end
        S_DATA_HI: begin
          if (accept) begin
            hi_byte_reg <= rx_data;
            csum_reg    <= csum_reg ^ rx_data;
            state_reg   <= S_DATA_LO;
          end
        end
        S_DATA_LO: begin
          if (accept) begin
            csum_reg     <= csum_reg ^ rx_data;
            wr_en        <= 1'b1;
            wr_addr      <= index_reg;
            wr_data      <= {hi_byte_reg, rx_data};
            words_loaded <= words_loaded + 1'b1;
            // Leave the index at the last address rather than wrapping it.
            if (index_reg == last_index_reg) begin
              state_reg <= S_CHECK;
            end else begin
              index_reg <= index_reg + 1'b1;
              state_reg <= S_DATA_HI;
            end
          end
        end
        S_CHECK: begin
          if (accept) begin
            if (rx_data == csum_reg) begin
              state_reg  <= S_DONE;
              done       <= 1'b1;
              cpu_enable <= 1'b1;
            end else begin
              state_reg <= S_ERROR;
              error     <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase

      if (timeout_hit) begin
        state_reg  <= S_ERROR;
        error      <= 1'b1;
        cpu_enable <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Self-checking bench for program_loader (ADDR_WIDTH=8, TIMEOUT_CYCLES=16).
// A table of short streams and randomized full-memory streams are checked
// against a stream-level reference model; timeout and mid-load reset corner
// cases are driven by hand-written sequences.
// -----------------------------------------------------------------------------
module tb_program_loader;

  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 16;

  logic          clk;
  logic          reset;
  logic          load_start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          cpu_enable;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_loaded;

  program_loader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load_start(load_start),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .cpu_enable(cpu_enable),
    .busy(busy),
    .done(done),
    .error(error),
    .words_loaded(words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks    = 0;
  int   failures  = 0;
  int   wr_count  = 0;
  logic prev_wr   = 1'b0;
  logic [7:0] stream [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Continuous properties: write strobe is a single cycle, CPU never enabled
  // while loading or after an error.
  always @(negedge clk) begin
    if (wr_en) begin
      check("wr_single_cycle", 32'(prev_wr), 32'd0);
      wr_count <= wr_count + 1;
    end
    if (busy || error) check("cpu_enable_off", 32'(cpu_enable), 32'd0);
    prev_wr <= wr_en;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: interprets the whole stream from the format rules.
  task automatic model(output int len, output bit len_ok, output bit good);
    logic [7:0] cs;
    len    = int'({stream[0], stream[1]});
    len_ok = (len >= 1) && (len <= (1 << AW));
    cs     = 8'h00;
    good   = 1'b0;
    if (len_ok) begin
      for (int i = 0; i < 2 * len; i++) cs = cs ^ stream[2 + i];
      good = (stream.size() > 2 + 2 * len) && (stream[2 + 2 * len] == cs);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit ls);
    repeat (gap) @(negedge clk);
    @(negedge clk);
    rx_data    = b;
    rx_valid   = 1'b1;
    load_start = ls;
    check("rx_ready", 32'(rx_ready), 32'd1);
    @(posedge clk);
    #1;
    rx_valid   = 1'b0;
    load_start = 1'b0;
    rx_data    = 8'($urandom);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    load_start = 1'b1;
    @(posedge clk);
    #1;
    load_start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
    check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
    check({tag, "_cpu_enable"}, 32'(cpu_enable), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_words_loaded"}, 32'(words_loaded), 32'd0);
  endtask

  // Runs the stream currently in 'stream'. abort_at >= 0 asserts reset right
  // after that byte is accepted and leaves reset high.
  task automatic do_load(input string tag, input int gap_max, input int abort_at);
    int len;
    bit len_ok;
    bit good;
    int nbytes;
    int start_count;
    bit aborted;
    model(len, len_ok, good);
    nbytes = len_ok ? 2 + 2 * len + 1 : 2;
    if (nbytes > stream.size()) nbytes = stream.size();
    aborted = 1'b0;
    start_count = wr_count;
    pulse_start();
    check({tag, "_start_busy"}, 32'(busy), 32'd1);
    check({tag, "_start_rx_ready"}, 32'(rx_ready), 32'd1);
    check({tag, "_start_error"}, 32'(error), 32'd0);
    check({tag, "_start_done"}, 32'(done), 32'd0);
    check({tag, "_start_words"}, 32'(words_loaded), 32'd0);
    for (int k = 0; k < nbytes; k++) begin
      if (k == nbytes - 1) check({tag, "_done_early"}, 32'(done), 32'd0);
      // A load_start during the load must be ignored.
      send_byte(stream[k], int'($urandom_range(gap_max, 0)), k == 4);
      if (len_ok && k >= 3 && k < 2 + 2 * len && ((k - 2) % 2 == 1)) begin
        check({tag, "_wr_en"}, 32'(wr_en), 32'd1);
        check({tag, "_wr_addr"}, 32'(wr_addr), 32'((k - 3) / 2));
        check({tag, "_wr_data"}, 32'(wr_data), 32'({stream[k - 1], stream[k]}));
      end
      if (k == abort_at) begin
        #1;
        reset = 1'b1;
        #1;
        check_all_zero({tag, "_async_reset"});
        aborted = 1'b1;
        break;
      end
    end
    if (!aborted) begin
      check({tag, "_done"}, 32'(done), 32'(good));
      check({tag, "_error"}, 32'(error), 32'(!good));
      check({tag, "_cpu_enable"}, 32'(cpu_enable), 32'(good));
      check({tag, "_busy_end"}, 32'(busy), 32'd0);
      check({tag, "_words_loaded"}, 32'(words_loaded), 32'(len_ok ? len : 0));
      @(negedge clk);
      #1;
      check({tag, "_write_count"}, 32'(wr_count - start_count), 32'(len_ok ? len : 0));
    end
  endtask

  typedef struct {
    string      name;
    logic [7:0] b [0:11];
    int         n;
    bit         exp_done;
    int         exp_words;
  } vec_t;

  vec_t vecs [5];

  task automatic build_random_full();
    logic [7:0] cs;
    logic [7:0] v;
    stream.delete();
    stream.push_back(8'h01);
    stream.push_back(8'h00);
    cs = 8'h00;
    for (int i = 0; i < 512; i++) begin
      v = 8'($urandom);
      cs = cs ^ v;
      stream.push_back(v);
    end
    stream.push_back(cs);
  endtask

  initial begin
    int snap;

    vecs[0] = '{"good3",   '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF, 8'hBF, 8'h00, 8'h00, 8'h00}, 9, 1'b1, 3};
    vecs[1] = '{"badsum3", '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00}, 9, 1'b0, 3};
    vecs[2] = '{"len0",    '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 1'b0, 0};
    vecs[3] = '{"len257",  '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 2, 1'b0, 0};
    vecs[4] = '{"good1",   '{8'h00, 8'h01, 8'h5A, 8'hA5, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5, 1'b1, 1};

    // Reset held with rx_valid high, then released: nothing happens until load_start.
    reset      = 1'b1;
    load_start = 1'b0;
    rx_valid   = 1'b1;
    rx_data    = 8'hAA;
    repeat (3) @(negedge clk);
    check_all_zero("in_reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_all_zero("after_reset");
    check("after_reset_no_writes", 32'(wr_count), 32'd0);
    rx_valid = 1'b0;

    // Table-driven short streams.
    foreach (vecs[i]) begin
      stream.delete();
      for (int j = 0; j < vecs[i].n; j++) stream.push_back(vecs[i].b[j]);
      do_load(vecs[i].name, 2, -1);
      check({vecs[i].name, "_tbl_done"}, 32'(done), 32'(vecs[i].exp_done));
      check({vecs[i].name, "_tbl_words"}, 32'(words_loaded), 32'(vecs[i].exp_words));
      $display("vector %s done=%0d error=%0d words=%0d", vecs[i].name, done, error, words_loaded);
    end

    // Timeout: stall after one DATA_HI byte, error after exactly 16 idle cycles.
    pulse_start();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    repeat (TO - 1) @(posedge clk);
    #1;
    check("timeout_not_yet_error", 32'(error), 32'd0);
    check("timeout_not_yet_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    check("timeout_error", 32'(error), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);
    check("timeout_cpu_enable", 32'(cpu_enable), 32'd0);
    $display("timeout stall error=%0d", error);

    // Timeout race: byte accepted on the 16th idle cycle wins.
    pulse_start();
    check("race_start_error", 32'(error), 32'd0);
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'h02, 0, 1'b0);
    send_byte(8'h11, 0, 1'b0);
    repeat (TO - 1) @(posedge clk);
    #1;
    send_byte(8'h22, 0, 1'b0);
    check("race_error", 32'(error), 32'd0);
    check("race_busy", 32'(busy), 32'd1);
    check("race_wr_en", 32'(wr_en), 32'd1);
    check("race_wr_data", 32'(wr_data), 32'h1122);
    send_byte(8'h33, 0, 1'b0);
    send_byte(8'h44, 0, 1'b0);
    send_byte(8'h44, 0, 1'b0);
    check("race_done", 32'(done), 32'd1);
    check("race_words", 32'(words_loaded), 32'd2);
    $display("timeout race done=%0d error=%0d", done, error);

    // Full 256-word load with random gaps.
    build_random_full();
    do_load("full256", 3, -1);
    check("full256_last_addr", 32'(wr_addr), 32'hFF);
    check("full256_words", 32'(words_loaded), 32'd256);
    $display("full256 done=%0d words=%0d last_addr=0x%0h", done, words_loaded, wr_addr);

    // Second full load, reset asserted right after a DATA_LO byte.
    build_random_full();
    do_load("abort256", 3, 201);
    snap = wr_count;
    repeat (3) @(negedge clk);
    reset    = 1'b0;
    rx_valid = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    check("abort_no_write_after_reset", 32'(wr_count), 32'(snap));
    check_all_zero("abort_idle");
    rx_valid = 1'b0;
    $display("abort256 writes_before_reset=%0d", snap);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time loader upstream of the S-Machine.
- Receives a byte-serial program image over a valid/ready link and assembles it into 16-bit instruction words.
- Writes those words into instruction memory through a dedicated write port, checks an XOR checksum, then raises the CPU enable.
- Holds the CPU disabled while loading and after any load error.

Parameters:
- ADDR_WIDTH, 8: instruction memory address width.
- DATA_WIDTH, 16: instruction word width; must equal 2 bytes.
- TIMEOUT_CYCLES, 1024: max idle cycles between accepted bytes while loading. 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERROR.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader accepts a byte this cycle.
- wr_en  out  1  instruction memory write strobe.
- wr_addr  out  ADDR_WIDTH  instruction memory write address.
- wr_data  out  DATA_WIDTH  instruction word.
- cpu_enable  out  1  drives the S-Machine enable input.
- busy  out  1  load in progress.
- done  out  1  last load succeeded.
- error  out  1  last load failed.
- words_loaded  out  ADDR_WIDTH+1  words written in the current/last load.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - All outputs 0, including wr_addr, wr_data and words_loaded.
  - Checksum accumulator, word index and timeout counter cleared.
  - Reset mid-load abandons the load. No further writes occur; already-written words are not reverted.
- Byte acceptance: a byte is accepted at a rising edge where rx_valid && rx_ready.
  - rx_ready is combinational from state: 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK.
  - rx_data is ignored when not accepted.
- Stream format: LEN_HI, LEN_LO, then LEN words, each high byte then low byte, then one checksum byte. Checksum = XOR of all data bytes only; length bytes are excluded.
- States:
  - IDLE: load_start -> LEN_HI.
  - LEN_HI: accept -> store high length byte -> LEN_LO.
  - LEN_LO: accept -> form LEN.
    - LEN == 0 or LEN > 2^ADDR_WIDTH -> ERROR.
    - Otherwise clear word index and checksum, -> DATA_HI.
  - DATA_HI: accept -> latch high byte, XOR into checksum -> DATA_LO.
  - DATA_LO: accept -> XOR into checksum. On the next cycle wr_en = 1 for exactly one cycle, with wr_addr = word index and wr_data = {hi, lo}. Word index and words_loaded then increment.
    - Index == LEN-1 -> CHECK.
    - Otherwise -> DATA_HI.
  - CHECK: accept -> byte == checksum ? DONE : ERROR.
  - DONE: done = 1, cpu_enable = 1, both registered (asserted the cycle after the CHECK byte is accepted).
  - ERROR: error = 1, cpu_enable = 0.
  - DONE/ERROR + load_start -> LEN_HI. done, error and cpu_enable clear, and words_loaded resets to 0, on that same edge.
- load_start while busy (LEN_HI..CHECK) is ignored.
- busy = 1 in LEN_HI..CHECK.
- Write latency: wr_en is asserted exactly 1 cycle after the DATA_LO acceptance edge. Back-to-back bytes may be accepted at full rate, so the peak write rate is one write every 2 cycles.
- Address range:
  - wr_addr ranges 0..LEN-1 and never wraps within a load.
  - LEN = 2^ADDR_WIDTH writes the top address last.
  - words_loaded reaches 2^ADDR_WIDTH without overflow.
- Timeout (TIMEOUT_CYCLES > 0):
  - The counter clears on every accepted byte and on entry to LEN_HI.
  - It increments each cycle in busy states with no acceptance.
  - On reaching TIMEOUT_CYCLES -> ERROR.
  - A byte accepted on the same edge as the timeout wins; no error is raised.
- cpu_enable is never 1 while busy or in ERROR.

Test Plan:
- Reset held then released with rx_valid = 1 -> all outputs 0, rx_ready = 0, state stays IDLE until load_start.
- load_start; bytes 00 03 12 34 AB CD 00 FF BF ->
  - Writes (0, 0x1234), (1, 0xABCD), (2, 0x00FF), each a single-cycle wr_en.
  - words_loaded = 3.
  - done = 1 and cpu_enable = 1 one cycle after BF is accepted.
- Same stream with checksum 0x00 ->
  - Three writes still occur.
  - error = 1, cpu_enable = 0.
  - A following load_start clears error and returns rx_ready = 1.
- Length 00 00 -> ERROR right after the second byte, no writes. Length 01 01 (257) -> ERROR.
- TIMEOUT_CYCLES = 16; stall after one DATA_HI byte -> error = 1 after exactly 16 idle cycles. A byte arriving on the 16th idle cycle -> no error.
- 256-word load with random rx_valid gaps, plus reset asserted mid-way on a second run ->
  - First run: last write at wr_addr = 0xFF, words_loaded = 256, done = 1.
  - Second run: outputs drop to 0 asynchronously at reset, with no write after reset.
